// File: rtl/state_sequencer_if.sv
// Status/control bundle between the multicycle datapath and the state sequencer.
// The datapath drives the master side and the sequencer uses the slave side.
interface state_sequencer_if #(
    parameter int STATE_W = 5,
    parameter int IR_W    = 16
);
    // Handshake: mem_ready is a one-cycle "access complete" strobe from memory.
    // The sequencer holds in a memory-wait state while mem_ready=0 and advances
    // in the first cycle it samples mem_ready=1. There is no back-pressure path.
    logic [IR_W-1:0]    IR;
    logic               compare;
    logic               carry_flag;
    logic               zero_flag;
    logic               mem_ready;
    logic [STATE_W-1:0] state_id;
    logic               instr_done;
    logic               illegal;
    logic [2:0]         lm_idx;

    modport master (
        output IR, compare, carry_flag, zero_flag, mem_ready,
        input  state_id, instr_done, illegal, lm_idx
    );

    modport slave (
        input  IR, compare, carry_flag, zero_flag, mem_ready,
        output state_id, instr_done, illegal, lm_idx
    );
endinterface

// File: rtl/state_sequencer.sv
// Next-state engine of the multicycle RISC core: decodes IR and steps the control states.
// Optional LM/SM multi-register transfers are enabled by defining SEQ_LMSM_EN.
module state_sequencer #(
    parameter int STATE_W = 5,
    parameter int IR_W    = 16,
    parameter int MASK_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    state_sequencer_if.slave  bus
);
    localparam logic [STATE_W-1:0] S_FETCH     = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE    = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_EXEC_R    = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_WB_R      = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_EXEC_I    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_WB_I      = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXEC_N    = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_LHI_WB    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_ADDR      = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_MEM_RD    = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_WB_MEM    = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_MEM_WR    = STATE_W'(11);
    localparam logic [STATE_W-1:0] S_BEQ_CMP   = STATE_W'(12);
    localparam logic [STATE_W-1:0] S_BEQ_TAKEN = STATE_W'(13);
    localparam logic [STATE_W-1:0] S_JAL_LINK  = STATE_W'(14);
    localparam logic [STATE_W-1:0] S_JAL_PC    = STATE_W'(15);
    localparam logic [STATE_W-1:0] S_JLR_PC    = STATE_W'(16);
    localparam logic [STATE_W-1:0] S_LMSM_SCAN = STATE_W'(18);
    localparam logic [STATE_W-1:0] S_LM_RD     = STATE_W'(19);
    localparam logic [STATE_W-1:0] S_LM_WB     = STATE_W'(20);
    localparam logic [STATE_W-1:0] S_SM_WR     = STATE_W'(21);
    localparam logic [STATE_W-1:0] S_TRAP      = STATE_W'(22);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_JLR = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1100;

    if (STATE_W < 5 || MASK_W < 1 || MASK_W > 8) begin : g_bad_param
        $error("state_sequencer: STATE_W must be >= 5 and MASK_W in 1..8");
    end

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               done_r;
    logic               done_nxt;
    logic               illegal_r;
    logic               illegal_nxt;
    logic [3:0]         opcode;
    logic               cond_ok;

    assign opcode = bus.IR[IR_W-1:IR_W-4];

    // ADD/NDU predication: 10 needs C, 01 needs Z, 00/11 always execute.
    always_comb begin
        case (bus.IR[1:0])
            2'b10:   cond_ok = bus.carry_flag;
            2'b01:   cond_ok = bus.zero_flag;
            default: cond_ok = 1'b1;
        endcase
    end

`ifdef SEQ_LMSM_EN
    logic [MASK_W-1:0] mask;
    logic [2:0]        lm_idx_r;
    logic [2:0]        low_idx;

    always_comb begin
        low_idx = 3'd0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) low_idx = 3'(i);
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_r    <= done_nxt;
            illegal_r <= illegal_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = S_TRAP;
        case (state)
            S_FETCH:  state_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_ADD:  state_nxt = cond_ok ? S_EXEC_R : S_FETCH;
                    OP_NDU:  state_nxt = cond_ok ? S_EXEC_N : S_FETCH;
                    OP_ADI:  state_nxt = S_EXEC_I;
                    OP_LHI:  state_nxt = S_LHI_WB;
                    OP_LW:   state_nxt = S_ADDR;
                    OP_SW:   state_nxt = S_ADDR;
                    OP_BEQ:  state_nxt = S_BEQ_CMP;
                    OP_JAL:  state_nxt = S_JAL_LINK;
                    OP_JLR:  state_nxt = S_JAL_LINK;
`ifdef SEQ_LMSM_EN
                    OP_LM:   state_nxt = S_LMSM_SCAN;
                    OP_SM:   state_nxt = S_LMSM_SCAN;
`endif
                    default: state_nxt = S_TRAP;
                endcase
            end
            S_EXEC_R:    state_nxt = S_WB_R;
            S_EXEC_N:    state_nxt = S_WB_R;
            S_WB_R:      state_nxt = S_FETCH;
            S_EXEC_I:    state_nxt = S_WB_I;
            S_WB_I:      state_nxt = S_FETCH;
            S_LHI_WB:    state_nxt = S_FETCH;
            S_ADDR:      state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    state_nxt = bus.mem_ready ? S_WB_MEM : S_MEM_RD;
            S_WB_MEM:    state_nxt = S_FETCH;
            S_MEM_WR:    state_nxt = bus.mem_ready ? S_FETCH : S_MEM_WR;
            S_BEQ_CMP:   state_nxt = bus.compare ? S_BEQ_TAKEN : S_FETCH;
            S_BEQ_TAKEN: state_nxt = S_FETCH;
            S_JAL_LINK:  state_nxt = (opcode == OP_JAL) ? S_JAL_PC : S_JLR_PC;
            S_JAL_PC:    state_nxt = S_FETCH;
            S_JLR_PC:    state_nxt = S_FETCH;
`ifdef SEQ_LMSM_EN
            S_LMSM_SCAN: begin
                if (mask == '0)          state_nxt = S_FETCH;
                else if (opcode == OP_LM) state_nxt = S_LM_RD;
                else                      state_nxt = S_SM_WR;
            end
            S_LM_RD:     state_nxt = bus.mem_ready ? S_LM_WB : S_LM_RD;
            S_LM_WB:     state_nxt = S_LMSM_SCAN;
            S_SM_WR:     state_nxt = bus.mem_ready ? S_LMSM_SCAN : S_SM_WR;
`endif
            default:     state_nxt = S_TRAP;
        endcase
    end

    // Output logic: done marks the first FETCH cycle after any instruction state.
    always_comb begin
        done_nxt    = (state_nxt == S_FETCH) && (state != S_FETCH);
        illegal_nxt = illegal_r | (state_nxt == S_TRAP);
    end

`ifdef SEQ_LMSM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mask     <= '0;
            lm_idx_r <= 3'd0;
        end else begin
            case (state)
                S_DECODE: if (opcode == OP_LM || opcode == OP_SM) mask <= bus.IR[MASK_W-1:0];
                S_LMSM_SCAN: if (mask != '0) lm_idx_r <= low_idx;
                S_LM_WB: mask[lm_idx_r] <= 1'b0;
                S_SM_WR: if (bus.mem_ready) mask[lm_idx_r] <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.lm_idx = lm_idx_r;
`else
    assign bus.lm_idx = 3'd0;
`endif

    assign bus.state_id   = state;
    assign bus.instr_done = done_r;
    assign bus.illegal    = illegal_r;
endmodule

// File: tb/tb_state_sequencer.sv
// Bench for state_sequencer: expected control-state traces are built per instruction
// from the instruction-level rules, then replayed cycle by cycle against the DUT.
module tb_state_sequencer;
    localparam int STATE_W = 5;
    localparam int IR_W    = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    state_sequencer_if #(.STATE_W(STATE_W), .IR_W(IR_W)) bus ();

    state_sequencer #(.STATE_W(STATE_W), .IR_W(IR_W), .MASK_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Per-cycle expected state plus the inputs to present in that cycle.
    logic [STATE_W-1:0] exp_q[$];
    logic               rdy_q[$];
    logic               c_q[$];
    logic               z_q[$];
    logic               cmp_q[$];
    int                 lm_q[$];
    logic               pending_done;
    logic               illegal_exp;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int st, input logic rdy, input logic c, input logic z,
                        input logic cmp, input int lm);
        exp_q.push_back(STATE_W'(st));
        rdy_q.push_back(rdy);
        c_q.push_back(c);
        z_q.push_back(z);
        cmp_q.push_back(cmp);
        lm_q.push_back(lm);
    endtask

    task automatic push_wait(input int st, input int n_wait, input int lm);
        repeat (n_wait) push(st, 1'b0, rb(), rb(), rb(), lm);
        push(st, 1'b1, rb(), rb(), rb(), lm);
    endtask

    // Instruction-level reference: lists the control states an instruction visits.
    task automatic build(input logic [15:0] ir, input int fw, input int mw,
                         input logic c, input logic z, input logic cmp);
        logic       take;
        logic [7:0] m;
        exp_q.delete(); rdy_q.delete(); c_q.delete(); z_q.delete(); cmp_q.delete(); lm_q.delete();
        push_wait(0, fw, -1);
        push(1, rb(), c, z, rb(), -1);
        m = ir[7:0];
        case (ir[15:12])
            4'h0, 4'h2: begin
                take = (ir[1:0] == 2'b10) ? c : (ir[1:0] == 2'b01) ? z : 1'b1;
                if (take) begin
                    push((ir[15:12] == 4'h0) ? 2 : 6, rb(), rb(), rb(), rb(), -1);
                    push(3, rb(), rb(), rb(), rb(), -1);
                end
            end
            4'h1: begin push(4, rb(), rb(), rb(), rb(), -1); push(5, rb(), rb(), rb(), rb(), -1); end
            4'h3: push(7, rb(), rb(), rb(), rb(), -1);
            4'h4: begin
                push(8, rb(), rb(), rb(), rb(), -1);
                push_wait(9, mw, -1);
                push(10, rb(), rb(), rb(), rb(), -1);
            end
            4'h5: begin push(8, rb(), rb(), rb(), rb(), -1); push_wait(11, mw, -1); end
            4'hC: begin
                push(12, rb(), rb(), rb(), cmp, -1);
                if (cmp) push(13, rb(), rb(), rb(), rb(), -1);
            end
            4'h8: begin push(14, rb(), rb(), rb(), rb(), -1); push(15, rb(), rb(), rb(), rb(), -1); end
            4'h9: begin push(14, rb(), rb(), rb(), rb(), -1); push(16, rb(), rb(), rb(), rb(), -1); end
`ifdef SEQ_LMSM_EN
            4'h6, 4'h7: begin
                push(18, rb(), rb(), rb(), rb(), -1);
                for (int b = 0; b < 8; b++) begin
                    if (m[b]) begin
                        if (ir[15:12] == 4'h6) begin
                            push_wait(19, mw, b);
                            push(20, rb(), rb(), rb(), rb(), b);
                        end else begin
                            push_wait(21, mw, b);
                        end
                        push(18, rb(), rb(), rb(), rb(), -1);
                    end
                end
            end
`endif
            default: repeat (4) push(22, rb(), rb(), rb(), rb(), -1);
        endcase
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            bus.mem_ready = rb(); bus.compare = rb(); bus.carry_flag = rb(); bus.zero_flag = rb();
            @(posedge clk); #1;
            check("reset/state", 32'(bus.state_id), 32'd0);
            check("reset/done", 32'(bus.instr_done), 32'd0);
            check("reset/illegal", 32'(bus.illegal), 32'd0);
            check("reset/lm_idx", 32'(bus.lm_idx), 32'd0);
        end
        reset = 1'b0;
        pending_done = 1'b0;
        illegal_exp  = 1'b0;
    endtask

    task automatic run(input string tag, input logic [15:0] ir, input int fw, input int mw,
                       input logic c, input logic z, input logic cmp, input int stop_at);
        int n;
        build(ir, fw, mw, c, z, cmp);
        n = exp_q.size();
        if (stop_at >= 0 && stop_at < n) n = stop_at;
        for (int i = 0; i < n; i++) begin
            bus.IR = ir; bus.mem_ready = rdy_q[i]; bus.carry_flag = c_q[i];
            bus.zero_flag = z_q[i]; bus.compare = cmp_q[i];
            if (exp_q[i] == STATE_W'(22)) illegal_exp = 1'b1;
            check({tag, "/state"}, 32'(bus.state_id), 32'(exp_q[i]));
            check({tag, "/done"}, 32'(bus.instr_done), (i == 0) ? 32'(pending_done) : 32'd0);
            check({tag, "/illegal"}, 32'(bus.illegal), 32'(illegal_exp));
`ifdef SEQ_LMSM_EN
            if (lm_q[i] >= 0) check({tag, "/lm_idx"}, 32'(bus.lm_idx), 32'(lm_q[i]));
`else
            check({tag, "/lm_idx"}, 32'(bus.lm_idx), 32'd0);
`endif
            @(posedge clk); #1;
        end
        pending_done = 1'b1;
        if (illegal_exp) do_reset(1);
    endtask

    initial begin
        logic [3:0] ops [0:15];
        logic [3:0] op;
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                4'h8, 4'h9, 4'hC, 4'h0, 4'h2, 4'hA, 4'hF, 4'h4};
        reset = 1'b1;
        bus.IR = '0; bus.mem_ready = 1'b0; bus.compare = 1'b0;
        bus.carry_flag = 1'b0; bus.zero_flag = 1'b0;
        pending_done = 1'b0; illegal_exp = 1'b0;
        @(posedge clk); #1;
        do_reset(2);

        // Reset in the middle of LW while waiting in MEM_RD
        run("lw_abort", 16'h4000, 0, 5, 1'b0, 1'b0, 1'b0, 5);
        do_reset(2);

        run("add", 16'h0000, 0, 0, 1'b0, 1'b0, 1'b0, -1);
        run("add_c0", 16'h0002, 0, 0, 1'b0, 1'b1, 1'b0, -1);
        run("add_c1", 16'h0002, 0, 0, 1'b1, 1'b0, 1'b0, -1);
        run("add_z0", 16'h0001, 1, 0, 1'b1, 1'b0, 1'b0, -1);
        run("add_z1", 16'h0001, 0, 0, 1'b0, 1'b1, 1'b0, -1);
        run("ndu", 16'h2003, 0, 0, 1'b0, 1'b0, 1'b0, -1);
        run("ndu_c0", 16'h2002, 0, 0, 1'b0, 1'b1, 1'b0, -1);
        run("adi", 16'h1234, 2, 0, 1'b0, 1'b0, 1'b0, -1);
        run("lhi", 16'h3FFF, 0, 0, 1'b0, 1'b0, 1'b0, -1);
        run("lw_wait", 16'h4000, 0, 3, 1'b0, 1'b0, 1'b0, -1);
        run("sw_wait", 16'h5000, 1, 2, 1'b0, 1'b0, 1'b0, -1);
        run("beq_t", 16'hC000, 0, 0, 1'b0, 1'b0, 1'b1, -1);
        run("beq_n", 16'hC000, 0, 0, 1'b0, 1'b0, 1'b0, -1);
        run("jal", 16'h8000, 0, 0, 1'b0, 1'b0, 1'b0, -1);
        run("jlr", 16'h9000, 0, 0, 1'b0, 1'b0, 1'b0, -1);
        run("lm", 16'h6005, 0, 0, 1'b0, 1'b0, 1'b0, -1);
        run("sm", 16'h7081, 0, 1, 1'b0, 1'b0, 1'b0, -1);
        run("lm_empty", 16'h6000, 0, 0, 1'b0, 1'b0, 1'b0, -1);
        run("trap", 16'hF000, 0, 0, 1'b0, 1'b0, 1'b0, -1);
        run("after_trap", 16'h0000, 0, 0, 1'b0, 1'b0, 1'b0, -1);

        for (int k = 0; k < 80; k++) begin
            op = ops[$urandom_range(0, 15)];
            run("rand", {op, 12'($urandom)}, $urandom_range(0, 2), $urandom_range(0, 2),
                rb(), rb(), rb(), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
